// File: rtl/p2s_tx.sv
// p2s_tx -- parallel-to-serial output transmitter for the MSDAP datapath.
//
// Takes one left and one right WIDTH-bit result word per frame into a holding
// register (load), then shifts both out MSB-first on out_l/out_r, one bit per
// sclk_en strobe. Words are sent back-to-back when the next one is already
// held. out_frame marks the MSB bit period, out_ready qualifies valid bits.
//
// Ports:
//   clk, reset_n    system clock, synchronous active-low reset
//   clear           synchronous clear, same effect as reset
//   en              permits starting a new word
//   load            captures data_l/data_r into the holding register
//   data_l, data_r  WIDTH-bit result words
//   sclk_en         bit strobe
//   mask            zero-word request, sampled at word start
//   out_l, out_r    serial data
//   out_frame       first-bit marker
//   out_ready       serial data valid
//   busy            word in progress
//   overrun         pulse when a load overwrites an unsent held word
//
// Optional macro: P2S_ZERO_MASK_EN -- when defined, a word started with
// mask=1 is transmitted as all zeros (held word still consumed). When
// undefined, mask is ignored.

// Per-channel holding register + shifter. Control comes from the top FSM.
module p2s_lane #(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             zero,
  input  logic             shift,
  input  logic             flush,
  output logic             out
);
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] sh;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      hold <= '0;
      sh   <= '0;
    end else begin
      if (load) hold <= data;
      // start reads the pre-load hold value, so a load coinciding with
      // consumption sends the old word and keeps the new one held
      if (start)      sh <= zero ? '0 : hold;
      else if (shift) sh <= {sh[WIDTH-2:0], 1'b0};
      else if (flush) sh <= '0;
    end
  end

  assign out = sh[WIDTH-1];
endmodule

module p2s_tx #(
  parameter int WIDTH = 40,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data_l,
  input  logic [WIDTH-1:0] data_r,
  input  logic             sclk_en,
  input  logic             mask,
  output logic             out_l,
  output logic             out_r,
  output logic             out_frame,
  output logic             out_ready,
  output logic             busy,
  output logic             overrun
);
  localparam int NUM_LANES = 2;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             hold_valid;

  logic at_end, start, shift, flush, zero;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_data;
  logic [NUM_LANES-1:0]            lane_out;

  assign at_end = (state == SHIFT) && (bit_cnt == '0);
  assign start  = sclk_en && hold_valid && en && ((state == IDLE) || at_end);
  assign shift  = sclk_en && (state == SHIFT) && (bit_cnt != '0);
  assign flush  = sclk_en && at_end && !start;

`ifdef P2S_ZERO_MASK_EN
  assign zero = mask;
`else
  assign zero = 1'b0;
  logic unused_mask;
  assign unused_mask = mask;
`endif

  assign lane_data = {data_r, data_l};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    p2s_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .load    (load),
      .data    (lane_data[i]),
      .start   (start),
      .zero    (zero),
      .shift   (shift),
      .flush   (flush),
      .out     (lane_out[i])
    );
  end

  assign out_l = lane_out[0];
  assign out_r = lane_out[1];

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      hold_valid <= 1'b0;
      out_frame  <= 1'b0;
      out_ready  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= load && hold_valid && !start;
      if (load)       hold_valid <= 1'b1;
      else if (start) hold_valid <= 1'b0;

      if (start) begin
        state     <= SHIFT;
        bit_cnt   <= CNT_W'(WIDTH-1);
        out_frame <= 1'b1;
        out_ready <= 1'b1;
        busy      <= 1'b1;
      end else if (sclk_en && state == SHIFT) begin
        out_frame <= 1'b0;
        if (bit_cnt != '0) begin
          bit_cnt <= bit_cnt - 1'b1;
        end else begin
          state     <= IDLE;
          out_ready <= 1'b0;
          busy      <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/p2s_tx.md
Name: p2s_tx

Overview:
- Parallel-to-serial output transmitter for the MSDAP datapath; serial counterpart of the input deserializer.
- Accepts one left and one right WIDTH-bit result word per frame from the ALU, then shifts both out MSB-first on two serial lines, one bit per bit-clock strobe.
- Generates the per-word frame marker and the output-valid qualifier.
- Sits between the ALU result registers and the chip output pins; driven by the top-level control FSM (load/clear/enable).

Parameters:
- WIDTH, 40, bits per output word per channel.
- CNT_W, 6, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous clear; aborts any word in progress.
- en  in  1  permits starting a new word.
- load  in  1  one-cycle strobe; captures data_l/data_r into the holding register.
- data_l  in  WIDTH  left-channel result word.
- data_r  in  WIDTH  right-channel result word.
- sclk_en  in  1  one-cycle bit strobe; at most one bit advance per strobe.
- mask  in  1  zero-word request (used only with P2S_ZERO_MASK_EN).
- out_l  out  1  left serial data.
- out_r  out  1  right serial data.
- out_frame  out  1  high during the first (MSB) bit period of each word.
- out_ready  out  1  high while out_l/out_r carry valid bits.
- busy  out  1  high in SHIFT state.
- overrun  out  1  one-cycle pulse when a load overwrites an unsent holding word.

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk. Reset has priority over everything.
- Reset and clear values: all outputs 0; shift registers, holding registers, hold_valid, bit_cnt all 0; state IDLE.
- clear behaves exactly as reset, one cycle; it aborts a word mid-shift and discards the held word.
- Holding register:
  - On load, hold_l/hold_r take data_l/data_r and hold_valid is set.
  - If load arrives while hold_valid=1 and the held word is not consumed that cycle, pulse overrun for 1 cycle; the new data overwrites the held word.
  - load in the same cycle as consumption: the old word goes to the shifter, the new word goes to hold, hold_valid stays 1, no overrun.
- FSM, two states: IDLE and SHIFT.
  - IDLE -> SHIFT when sclk_en && hold_valid && en:
    - shift regs <= hold, hold_valid <= 0, bit_cnt <= WIDTH-1.
    - out_frame <= 1, out_ready <= 1, busy <= 1.
  - In SHIFT, each sclk_en:
    - out_frame <= 0.
    - If bit_cnt != 0: shift both registers left by 1 with 0 fill; bit_cnt decrements.
    - If bit_cnt == 0 and hold_valid && en: restart back-to-back, exactly as the IDLE->SHIFT start (no idle bit, out_frame=1 again).
    - If bit_cnt == 0 otherwise: go to IDLE; out_ready, busy, shift regs <= 0.
  - In either state, no change without sclk_en.
- out_l/out_r are the MSBs of their shift registers (registered outputs, no combinational path from inputs).
- Latency: the first bit appears the cycle after the first sclk_en that follows load. A word occupies exactly WIDTH sclk_en periods.
- en deasserted mid-word: the current word completes; a pending word stays held until en=1.
- sclk_en coincident with load in IDLE with hold_valid=0: the word is not started this strobe (captured only).

Optional Feature:
- Macro: P2S_ZERO_MASK_EN.
- Defined: mask is sampled at word start. If mask=1, the shift registers load all zeros instead of hold, while hold is still consumed and out_frame/out_ready behave normally. This is sleep-mode output of zero samples.
- Undefined: the mask port exists but is ignored; words are always transmitted as held.

Test Plan:
- Reset/idle: reset_n=0 for 2 cycles, then sclk_en every 4 cycles with no load -> all outputs stay 0, busy=0.
- Single word: load data_l=40'h80_0000_0001, data_r=40'h55_AAAA_5555, en=1, sclk_en every 4 cycles -> out_frame high for first bit only; 40 bits serialized MSB-first match both words; out_ready falls after bit 40.
- Back-to-back: second load during bit 20 of the first word -> second word starts on the strobe after bit 40 with out_frame=1, no gap, no overrun.
- Overrun: two loads (values A, B) while a word is shifting -> overrun pulses once on the second load; B is sent next, A is never sent.
- Clear mid-word: clear at bit 15 -> next cycle out_l/out_r/out_ready/busy=0; held word discarded; no output on subsequent strobes.
- Mask (P2S_ZERO_MASK_EN defined): load 40'hFF_FFFF_FFFF with mask=1 -> 40 zero bits, out_frame/out_ready normal; with the macro undefined -> 40 one bits.
